// File: rtl/mac_tap_if.sv
// Handshake and datapath-control bundle between the frame controller and the MAC tap sequencer.
// The sequencer is the slave of start/abort/out_ready and drives every other signal.
interface mac_tap_if #(
  parameter int ADDR_W = 4,
  parameter int OIDX_W = 4
);
  logic              start;
  logic              abort;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              acc_clr;
  logic              mac_en;
  logic [ADDR_W-1:0] tap_addr;
  logic [OIDX_W-1:0] out_idx;
  logic              out_valid;

  modport master (
    output start, abort, out_ready,
    input  busy, done, acc_clr, mac_en, tap_addr, out_idx, out_valid
  );

  modport slave (
    input  start, abort, out_ready,
    output busy, done, acc_clr, mac_en, tap_addr, out_idx, out_valid
  );
endinterface

// File: rtl/mac_tap_sequencer.sv
// Control FSM that steps a MAC unit through N_TAPS addresses per output, waits out the
// MAC pipeline, and offers each result downstream; N_OUTS outputs make up one frame.
module mac_tap_sequencer #(
  parameter int N_TAPS  = 14,
  parameter int N_OUTS  = 16,
  parameter int MAC_LAT = 2,
  parameter int ADDR_W  = 4,
  parameter int OIDX_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  mac_tap_if.slave       bus
);

  // The flush counter only ever holds 0..MAC_LAT-1.
  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [ADDR_W-1:0] TAP_LAST = ADDR_W'(N_TAPS - 1);
  localparam logic [OIDX_W-1:0] OUT_LAST = OIDX_W'(N_OUTS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_FLUSH,
    S_OUTPUT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tap_addr_q, tap_addr_d;
  logic [OIDX_W-1:0] out_idx_q, out_idx_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  // NOTE: every sequential register uses non-blocking assignments so all flops
  // update together on the edge regardless of statement order.
  // NOTE: the reset is asynchronous, so it must appear in the sensitivity list;
  // all state and counters are cleared because outputs decode from them directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tap_addr_q <= '0;
      out_idx_q  <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      tap_addr_q <= tap_addr_d;
      out_idx_q  <= out_idx_d;
      lat_q      <= lat_d;
    end
  end

  // NOTE: every signal written here is given a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    tap_addr_d = tap_addr_q;
    out_idx_d  = out_idx_q;
    lat_d      = lat_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        tap_addr_d = '0;
        state_d    = S_ACCUM;
      end
      S_ACCUM: begin
        if (tap_addr_q == TAP_LAST) begin
          tap_addr_d = '0;
          lat_d      = '0;
          state_d    = (MAC_LAT == 0) ? S_OUTPUT : S_FLUSH;
        end else begin
          tap_addr_d = tap_addr_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (lat_q == LAT_LAST) state_d = S_OUTPUT;
        else                   lat_d   = lat_q + 1'b1;
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          if (out_idx_q == OUT_LAST) begin
            state_d = S_DONE;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
            state_d   = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        out_idx_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides the handshake and any counter wrap decided above.
    if (state_q != S_IDLE && bus.abort) begin
      state_d    = S_IDLE;
      tap_addr_d = '0;
      out_idx_d  = '0;
      lat_d      = '0;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.acc_clr   = (state_q == S_CLEAR);
  assign bus.mac_en    = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_OUTPUT);
  assign bus.tap_addr  = tap_addr_q;
  assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Self-checking bench: a position-in-frame reference model predicts every output each cycle,
// with directed frames, abort, async reset, random traffic and a minimal-parameter instance.
module tb_mac_tap_sequencer;

  localparam int N   = 14;
  localparam int L   = 2;
  localparam int O   = 16;
  localparam int PER = N + L + 2;

  logic clk;
  logic rst;

  mac_tap_if #(.ADDR_W(4), .OIDX_W(4)) m_if ();
  mac_tap_if #(.ADDR_W(1), .OIDX_W(1)) s_if ();

  mac_tap_sequencer #(
    .N_TAPS(N), .N_OUTS(O), .MAC_LAT(L), .ADDR_W(4), .OIDX_W(4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  mac_tap_sequencer #(
    .N_TAPS(1), .N_OUTS(1), .MAC_LAT(0), .ADDR_W(1), .OIDX_W(1)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: where the frame is, not which FSM state holds it.
  // m_pos 0 = clear slot, 1..N = tap slots, N+1..N+L = drain, PER-1 = result slot.
  bit m_busy;
  bit m_done;
  int m_pos;
  int m_out;

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_pos = 0; m_out = 0;
  endfunction

  function automatic void model_step(input logic st, input logic ab, input logic rdy);
    if (!m_busy) begin
      if (st && !ab) begin
        m_busy = 1; m_done = 0; m_pos = 0; m_out = 0;
      end
    end else if (ab) begin
      model_reset();
    end else if (m_done) begin
      model_reset();
    end else if (m_pos == PER - 1) begin
      if (rdy) begin
        if (m_out == O - 1) m_done = 1;
        else begin
          m_out++;
          m_pos = 0;
        end
      end
    end else begin
      m_pos++;
    end
  endfunction

  // Packing: [12]busy [11]done [10]acc_clr [9]mac_en [8]out_valid [7:4]tap_addr [3:0]out_idx
  function automatic logic [12:0] exp_vec();
    logic act, dn, clr, en, vld;
    int   tap;
    act = m_busy && !m_done;
    dn  = m_busy && m_done;
    clr = act && (m_pos == 0);
    en  = act && (m_pos >= 1) && (m_pos <= N);
    vld = act && (m_pos == PER - 1);
    tap = en ? m_pos - 1 : 0;
    return {m_busy, dn, clr, en, vld, 4'(tap), 4'(m_out)};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {m_if.busy, m_if.done, m_if.acc_clr, m_if.mac_en, m_if.out_valid,
            m_if.tap_addr, m_if.out_idx};
  endfunction

  int          cnt_busy, cnt_done, cnt_en, cnt_clr, cnt_v3;
  logic [12:0] last_obs;

  task automatic clear_stats();
    cnt_busy = 0; cnt_done = 0; cnt_en = 0; cnt_clr = 0; cnt_v3 = 0;
  endtask

  // Called at posedge+1: drive inputs, compare at negedge, advance model on the edge.
  task automatic cycle(input logic st, input logic ab, input logic rdy);
    m_if.start     = st;
    m_if.abort     = ab;
    m_if.out_ready = rdy;
    @(negedge clk);
    last_obs = obs_vec();
    check("outputs", 32'(last_obs), 32'(exp_vec()));
    if (m_if.busy)      cnt_busy++;
    if (m_if.done)      cnt_done++;
    if (m_if.mac_en)    cnt_en++;
    if (m_if.acc_clr)   cnt_clr++;
    if (m_if.out_valid && m_if.out_idx == 4'd3) cnt_v3++;
    @(posedge clk);
    model_step(st, ab, rdy);
    #1;
  endtask

  task automatic full_frame(input string tag);
    int budget;
    clear_stats();
    cycle(1'b1, 1'b0, 1'b1);
    budget = 0;
    while (m_busy && budget < 400) begin
      cycle(1'b0, 1'b0, 1'b1);
      budget++;
    end
    check({tag, "_idle_timeout"}, 32'(m_if.busy), 32'd0);
    check({tag, "_busy_cycles"}, cnt_busy, O * PER + 1);
    check({tag, "_done_pulses"}, cnt_done, 1);
    check({tag, "_mac_en_cycles"}, cnt_en, O * N);
    check({tag, "_acc_clr_cycles"}, cnt_clr, O);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   budget, stall;
    logic rdy, ab, st;
    int   s_busy, s_en, s_done, s_clr, s_tap_bad;

    rst = 1'b1;
    m_if.start = 1'b0; m_if.abort = 1'b0; m_if.out_ready = 1'b0;
    s_if.start = 1'b0; s_if.abort = 1'b0; s_if.out_ready = 1'b1;
    model_reset();
    #2;
    check("reset_state", 32'(obs_vec()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle with no start stays idle.
    repeat (3) cycle(1'b0, 1'b0, 1'b1);

    // Plain frame, ready held high.
    full_frame("frame1");

    // Five-cycle stall on output 3.
    clear_stats();
    stall = 0;
    cycle(1'b1, 1'b0, 1'b1);
    budget = 0;
    while (m_busy && budget < 400) begin
      rdy = !((m_pos == PER - 1) && !m_done && (m_out == 3) && (stall < 5));
      if (!rdy) stall++;
      cycle(1'b0, 1'b0, rdy);
      budget++;
    end
    check("stall_busy_cycles", cnt_busy, O * PER + 1 + 5);
    check("stall_valid_hold", cnt_v3, 6);

    // Abort during tap 7 of output 2.
    clear_stats();
    cycle(1'b1, 1'b0, 1'b1);
    budget = 0;
    while (m_busy && budget < 400) begin
      ab = (m_pos == 8) && (m_out == 2) && !m_done;
      cycle(1'b0, ab, 1'b1);
      budget++;
    end
    check("abort_no_done", cnt_done, 0);
    check("abort_busy", 32'(m_if.busy), 32'd0);
    check("abort_tap_addr", 32'(m_if.tap_addr), 32'd0);
    check("abort_out_idx", 32'(m_if.out_idx), 32'd0);
    check("abort_busy_cycles", cnt_busy, 2 * PER + 9);
    full_frame("after_abort");

    // Start re-pulsed mid-frame and on the done cycle is ignored.
    clear_stats();
    cycle(1'b1, 1'b0, 1'b1);
    budget = 0;
    while (m_busy && budget < 400) begin
      st = ((m_pos == 5) && (m_out == 7)) || m_done;
      cycle(st, 1'b0, 1'b1);
      budget++;
    end
    check("restart_ignored_busy", cnt_busy, O * PER + 1);
    check("restart_ignored_done", cnt_done, 1);
    cycle(1'b1, 1'b0, 1'b1);
    check("restart_idle_cycle", 32'(last_obs[12]), 32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    check("restart_acc_clr", 32'(last_obs[10]), 32'd1);
    cycle(1'b0, 1'b1, 1'b1);

    // Asynchronous reset while draining the MAC pipeline.
    cycle(1'b1, 1'b0, 1'b1);
    budget = 0;
    while (!(m_busy && m_pos == N + 1) && budget < 100) begin
      cycle(1'b0, 1'b0, 1'b1);
      budget++;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'(obs_vec()), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) cycle(1'b0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 19) == 0);
      ab  = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cycle(st, ab, rdy);
    end
    budget = 0;
    while (m_busy && budget < 400) begin
      cycle(1'b0, 1'b0, 1'b1);
      budget++;
    end

    // Minimal instance: 1 tap, 1 output, no MAC latency.
    s_busy = 0; s_en = 0; s_done = 0; s_clr = 0; s_tap_bad = 0;
    s_if.start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_if.busy)    s_busy++;
      if (s_if.mac_en)  s_en++;
      if (s_if.done)    s_done++;
      if (s_if.acc_clr) s_clr++;
      if (s_if.mac_en && s_if.tap_addr != 1'b0) s_tap_bad++;
      @(posedge clk);
      #1 s_if.start = 1'b0;
    end
    check("small_busy_cycles", s_busy, 4);
    check("small_mac_en", s_en, 1);
    check("small_done", s_done, 1);
    check("small_acc_clr", s_clr, 1);
    check("small_tap_addr", s_tap_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
